// File: rtl/ahb_cmd_arb.sv
// Round-robin arbiter that serialises single-word commands from NREQ sources onto one AHB-lite master port.
// Optional wait-state timeout is enabled by defining AHB_ARB_TIMEOUT_EN (limit TMO_CYC stalled cycles).
module ahb_cmd_arb #(
  parameter int NREQ    = 4,
  parameter int TMO_CYC = 255
) (
  input  logic                hclk,
  input  logic                hrst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ-1:0]     req_write,
  input  logic [NREQ*32-1:0]  req_addr,
  input  logic [NREQ*32-1:0]  req_wdata,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic [1:0]          htrans,
  output logic                hwrite,
  output logic [31:0]         haddr,
  output logic [31:0]         hwdata,
  output logic [1:0]          hsize,
  output logic [2:0]          hburst,
  output logic [3:0]          hprot,
  output logic                hready_out,
  input  logic                hready_in,
  input  logic [1:0]          hresp,
  input  logic [31:0]         hrdata
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
  localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   last_grant_reg, last_grant_next;
  logic [GW-1:0]   grant_reg, grant_next;
  logic            write_reg, write_next;
  logic [31:0]     addr_reg, addr_next;
  logic [31:0]     wdata_reg, wdata_next;
  logic [31:0]     rdata_reg, rdata_next;
  logic            err_reg, err_next;

  logic [31:0]     addr_arr  [NREQ];
  logic [31:0]     wdata_arr [NREQ];
  logic [NREQ-1:0] unused_lsb;

  // Word-align addresses as they are unpacked; the byte offset bits are discarded.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]   = {req_addr[32*gi+2 +: 30], 2'b00};
      assign wdata_arr[gi]  = req_wdata[32*gi +: 32];
      assign unused_lsb[gi] = ^req_addr[32*gi +: 2];
    end
  endgenerate

  logic            win_found;
  logic [GW-1:0]   win_idx;
  logic [GW-1:0]   cand_idx;
  logic [NREQ-1:0] win_onehot;
  logic [NREQ-1:0] rsp_onehot;
  logic            tmo_hit;

  // Search begins just after the previous winner and wraps, so every source gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_idx = GW'((int'(last_grant_reg) + k) % NREQ);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
    rsp_onehot            = '0;
    rsp_onehot[grant_reg] = 1'b1;
  end

`ifdef AHB_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_reg, tmo_cnt_next;

  assign tmo_hit = !hready_in && (tmo_cnt_reg == TMO_LAST);

  always_comb begin
    tmo_cnt_next = '0;
    if (state_next == state_reg && (state_reg == ADDR || state_reg == DATA))
      tmo_cnt_next = tmo_cnt_reg + 16'd1;
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) tmo_cnt_reg <= '0;
    else      tmo_cnt_reg <= tmo_cnt_next;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_LAST;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_reg;
    write_next      = write_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    rdata_next      = rdata_reg;
    err_next        = err_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          grant_next      = win_idx;
          last_grant_next = win_idx;
          write_next      = req_write[win_idx];
          addr_next       = addr_arr[win_idx];
          wdata_next      = wdata_arr[win_idx];
          state_next      = ADDR;
        end
      end
      ADDR: begin
        if (hready_in) begin
          state_next = DATA;
        end else if (tmo_hit) begin
          state_next = RESP;
          rdata_next = TMO_DATA;
          err_next   = 1'b1;
        end
      end
      DATA: begin
        if (hready_in) begin
          state_next = RESP;
          rdata_next = write_reg ? 32'h0 : hrdata;
          err_next   = |hresp;
        end else if (tmo_hit) begin
          state_next = RESP;
          rdata_next = TMO_DATA;
          err_next   = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state_reg      <= IDLE;
      last_grant_reg <= GW'(NREQ - 1);
      grant_reg      <= '0;
      write_reg      <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
      write_reg      <= write_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      rdata_reg      <= rdata_next;
      err_reg        <= err_next;
    end
  end

  // Gated by hrst so no source sees an accept while the block is held in reset.
  assign req_ready  = (state_reg == IDLE && win_found && !hrst) ? win_onehot : '0;
  assign rsp_valid  = (state_reg == RESP) ? rsp_onehot : '0;
  assign rsp_rdata  = rdata_reg;
  assign rsp_err    = err_reg;
  assign htrans     = (state_reg == ADDR) ? 2'b10 : 2'b00;
  assign hwrite     = write_reg;
  assign haddr      = addr_reg;
  assign hwdata     = wdata_reg;
  assign hsize      = 2'b10;
  assign hburst     = 3'b000;
  assign hprot      = 4'b0011;
  assign hready_out = hready_in;

endmodule

// File: tb/tb_ahb_cmd_arb.sv
// Scoreboard bench for ahb_cmd_arb: reactive AHB slave model, round-robin grant model and response queue.
module tb_ahb_cmd_arb;
  localparam int NREQ = 4;
  localparam int TMO  = 16;
  localparam logic [31:0] ERR_ADDR = 32'h0000_0040;

  logic                clk;
  logic                hrst;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_write = '0;
  logic [NREQ*32-1:0]  req_addr  = '0;
  logic [NREQ*32-1:0]  req_wdata = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     rsp_valid;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic [1:0]          htrans;
  logic                hwrite;
  logic [31:0]         haddr;
  logic [31:0]         hwdata;
  logic [1:0]          hsize;
  logic [2:0]          hburst;
  logic [3:0]          hprot;
  logic                hready_out;
  logic                hready_in = 1'b1;
  logic [1:0]          hresp     = 2'b00;
  logic [31:0]         hrdata    = '0;

  ahb_cmd_arb #(.NREQ(NREQ), .TMO_CYC(TMO)) dut (
    .hclk(clk), .hrst(hrst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .htrans(htrans), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready_out(hready_out),
    .hready_in(hready_in), .hresp(hresp), .hrdata(hrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          grant_log[$];
  logic [31:0] mem [logic [31:0]];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          m_last = NREQ - 1;
  int          m_free = 0;
  int          acc_cnt [NREQ];
  int          seen_cnt[NREQ];
  logic [NREQ-1:0] hold = '0;
  logic        s_stall = 1'b0;
  int          s_aw = 0;
  int          s_dw = 0;
  int          s_phase = 0, s_acnt = 0, s_dcnt = 0;
  logic        s_errf = 1'b0;
  logic [31:0] s_addr = '0;
  logic        s_wr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic int rr(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (last + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Monitor, grant/response model and AHB slave, all evaluated away from the active edge.
  always @(negedge clk) begin
    exp_t            e;
    logic [NREQ-1:0] exp_rv;
    logic [NREQ-1:0] exp_rdy;
    int              w;
    cyc++;
    if (hrst) begin
      check("rst_req_ready", 32'(req_ready), 32'h0);
      sb.delete();
      m_last = NREQ - 1;
      m_free = 0;
      s_phase = 0; s_acnt = 0; s_dcnt = 0; s_errf = 1'b0;
      hready_in = 1'b1;
      hresp = 2'b00;
    end else begin
      exp_rv = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) exp_rv[sb[0].idx] = 1'b1;
      if (exp_rv != 0 || rsp_valid != 0) check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv != 0) begin
        e = sb.pop_front();
        $display("[%0d] rsp req%0d %s addr=%h rdata=%h err=%b", cyc, e.idx, e.wr ? "WR" : "RD", e.addr, rsp_rdata, rsp_err);
        if (e.chk_rd) check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end

      w = (cyc >= m_free) ? rr(req_valid, m_last) : -1;
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) grant_log.push_back(i);

      if (w >= 0) begin
        e.idx = w;
        e.wr = req_write[w];
        e.addr = {req_addr[32*w+2 +: 30], 2'b00};
        e.wdata = req_wdata[32*w +: 32];
        e.chk_rd = 1'b1;
        if (s_stall) begin
`ifdef AHB_ARB_TIMEOUT_EN
          e.rdata = 32'hDEAD_BEEF;
          e.err = 1'b1;
          e.cyc = cyc + 1 + TMO;
          sb.push_back(e);
          m_free = e.cyc + 1;
`else
          m_free = 32'h7FFF_FFFF;
`endif
        end else begin
          e.err = (e.addr == ERR_ADDR);
          e.rdata = e.wr ? 32'h0 : mem_rd(e.addr);
          e.chk_rd = !e.err;
          e.cyc = cyc + 3 + s_aw + s_dw + (e.err ? 1 : 0);
          sb.push_back(e);
          m_free = e.cyc + 1;
        end
        m_last = w;
        acc_cnt[w]++;
      end

      if (s_stall) begin
        hready_in = 1'b0;
        hresp = 2'b00;
      end else if (s_phase == 0) begin
        hresp = 2'b00;
        hready_in = 1'b1;
        if (htrans == 2'b10) begin
          if (s_acnt < s_aw) begin
            hready_in = 1'b0;
            s_acnt++;
          end else begin
            s_acnt = 0;
            s_phase = 1;
            s_addr = haddr;
            s_wr = hwrite;
            if (sb.size() > 0) begin
              check("haddr", haddr, sb[0].addr);
              check("hwrite", 32'(hwrite), 32'(sb[0].wr));
            end else begin
              check("nonseq_unexpected", 32'(htrans), 32'h0);
            end
          end
        end
      end else begin
        if (s_dcnt < s_dw) begin
          hready_in = 1'b0;
          hresp = 2'b00;
          s_dcnt++;
        end else if (s_addr == ERR_ADDR && !s_errf) begin
          hready_in = 1'b0;
          hresp = 2'b01;
          s_errf = 1'b1;
        end else begin
          hready_in = 1'b1;
          hresp = (s_addr == ERR_ADDR) ? 2'b01 : 2'b00;
          s_errf = 1'b0;
          s_dcnt = 0;
          s_phase = 0;
          if (s_wr) begin
            hrdata = 32'hFFFF_FFFF;
            if (sb.size() > 0) begin
              check("hwdata", hwdata, sb[0].wdata);
              mem[s_addr] = sb[0].wdata;
            end
          end else begin
            hrdata = mem_rd(s_addr);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_cnt[i] != seen_cnt[i]) begin
        seen_cnt[i] = acc_cnt[i];
        if (!hold[i]) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic post(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_write[i] = wr;
    req_addr[32*i +: 32] = a;
    req_wdata[32*i +: 32] = d;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget; n++) begin
      step();
      if (req_valid == 0 && sb.size() == 0) return;
    end
    check("wait_budget", 32'(req_valid) | 32'(sb.size()), 32'h0);
  endtask

  initial begin
    int base;
    for (int i = 0; i < NREQ; i++) begin
      acc_cnt[i] = 0;
      seen_cnt[i] = 0;
    end
    mem[32'h0000_0014] = 32'h1234_5678;
    hrst = 1'b1;
    step();
    step();
    check("rst_htrans", 32'(htrans), 32'h0);
    check("rst_hwrite", 32'(hwrite), 32'h0);
    check("rst_haddr", haddr, 32'h0);
    check("rst_hwdata", hwdata, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    hrst = 1'b0;
    step();

    // Single read, zero-wait, then a write with data-phase waits and its read-back.
    post(0, 1'b0, 32'h0000_0014, 32'h0);
    wait_idle(50);
    s_dw = 3;
    post(2, 1'b1, 32'h0000_0023, 32'hA5A5_0001);
    wait_idle(50);
    s_dw = 0;
    post(1, 1'b0, 32'h0000_0020, 32'h0);
    wait_idle(50);
    s_aw = 2;
    post(3, 1'b0, 32'h0000_0088, 32'h0);
    wait_idle(50);
    s_aw = 0;

    // Slave error, then a normal transfer.
    post(1, 1'b0, ERR_ADDR, 32'h0);
    wait_idle(50);
    post(2, 1'b0, 32'h0000_0044, 32'h0);
    wait_idle(50);

    // All requesters continuously valid across a reset release.
    for (int i = 0; i < NREQ; i++) begin
      req_write[i] = 1'b0;
      req_addr[32*i +: 32] = 32'h100 + 32'(4 * i);
    end
    hold = '1;
    req_valid = '1;
    hrst = 1'b1;
    step();
    step();
    hrst = 1'b0;
    base = grant_log.size();
    for (int n = 0; n < 100; n++) begin
      step();
      if (grant_log.size() - base >= 5) break;
    end
    req_valid = '0;
    hold = '0;
    wait_idle(50);
    check("rr_count", 32'(grant_log.size() - base), 32'd5);
    for (int k = 0; k < 5 && base + k < grant_log.size(); k++)
      check("rr_order", 32'(grant_log[base + k]), 32'(k % NREQ));

    // Reset during the data phase drops the command and restores requester 0 priority.
    s_dw = 10;
    post(0, 1'b0, 32'h0000_0060, 32'h0);
    for (int n = 0; n < 20 && htrans != 2'b10; n++) step();
    step();
    hrst = 1'b1;
    #1;
    check("midrst_htrans", 32'(htrans), 32'h0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst_haddr", haddr, 32'h0);
    step();
    s_dw = 0;
    hrst = 1'b0;
    step();
    base = grant_log.size();
    post(1, 1'b0, 32'h0000_0064, 32'h0);
    post(0, 1'b0, 32'h0000_0068, 32'h0);
    wait_idle(50);
    check("post_rst_first", (grant_log.size() > base) ? 32'(grant_log[base]) : 32'hFFFF_FFFF, 32'd0);

    // Slave stalls indefinitely.
    s_stall = 1'b1;
    post(3, 1'b0, 32'h0000_0070, 32'h0);
    repeat (40) step();
`ifdef AHB_ARB_TIMEOUT_EN
    check("stall_htrans", 32'(htrans), 32'h0);
    check("stall_drained", 32'(sb.size()), 32'h0);
`else
    check("stall_htrans", 32'(htrans), 32'h2);
`endif
    hrst = 1'b1;
    step();
    s_stall = 1'b0;
    hrst = 1'b0;
    step();
    post(2, 1'b0, 32'h0000_0014, 32'h0);
    wait_idle(50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
